// File: rtl/pulse_meter_pkg.sv
// Shared definitions for the pulse measurement blocks (pulse_meter, univib).
package pulse_meter_pkg;

  // Measurement FSM states.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEASURE  = 2'd1,
    OVERLONG = 2'd2
  } meter_state_e;

  // Number of flops in the input synchronizer; s is valid this many cycles after reset.
  localparam int unsigned SyncStages = 2;

  // Width of a counter able to hold 0..max_ticks inclusive.
  function automatic int unsigned len_width(input int unsigned max_ticks);
    return $clog2(max_ticks + 1);
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous level, cleared to 0 by reset.
module sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  // Shift the raw input through two flops to settle metastability.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/pulse_meter.sv
// Measures the length of high pulses on an asynchronous input and reports
// accepted / too-short / too-long outcomes as one-cycle registered strobes.
module pulse_meter
  import pulse_meter_pkg::*;
#(
  parameter int unsigned MIN_TICKS = 3,
  parameter int unsigned MAX_TICKS = 8
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                pin,
  output logic                                ok,
  output logic                                err_short,
  output logic                                err_long,
  output logic [len_width(MAX_TICKS)-1:0]     len,
  output logic                                busy
);

  localparam int unsigned LenW = len_width(MAX_TICKS);
  localparam logic [LenW-1:0] MaxCnt = LenW'(MAX_TICKS);
  localparam logic [LenW-1:0] MinCnt = LenW'(MIN_TICKS);
  localparam logic [LenW-1:0] OneCnt = LenW'(1);

  logic s;
  logic s_d_q;

  meter_state_e state_q, state_d;
  logic [LenW-1:0] cnt_q, cnt_d;
  logic [LenW-1:0] len_q, len_d;
  logic armed_q, armed_d;
  logic ok_q, ok_d;
  logic short_q, short_d;
  logic long_q, long_d;
  // Shift register of ones after reset: s only reflects pin once it has filled,
  // so the reset-cleared synchronizer cannot fake a low level and arm the block.
  logic [SyncStages-1:0] settle_q;

  sync2 u_sync2 (
    .clk   (clk),
    .reset (reset),
    .d     (pin),
    .q     (s)
  );

  // Third flop for rising-edge detection and the post-reset settle tracker.
  always_ff @(posedge clk) begin
    if (reset) begin
      s_d_q    <= 1'b0;
      settle_q <= '0;
    end else begin
      s_d_q    <= s;
      settle_q <= {settle_q[SyncStages-2:0], 1'b1};
    end
  end

  // Next-state, counter, length and strobe decisions.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    armed_d = armed_q;
    ok_d    = 1'b0;
    short_d = 1'b0;
    long_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!s) begin
          // Only trust a low once the synchronizer holds real pin samples.
          if (settle_q[SyncStages-1]) begin
            armed_d = 1'b1;
          end
        end else if (!s_d_q && armed_q) begin
          state_d = MEASURE;
          cnt_d   = OneCnt;
          armed_d = 1'b0;
        end
      end

      MEASURE: begin
        if (s) begin
          if (cnt_q < MaxCnt) begin
            cnt_d = cnt_q + OneCnt;
          end else begin
            long_d  = 1'b1;
            len_d   = MaxCnt;
            state_d = OVERLONG;
          end
        end else begin
          len_d = cnt_q;
          if (cnt_q >= MinCnt) begin
            ok_d = 1'b1;
          end else begin
            short_d = 1'b1;
          end
          state_d = IDLE;
          // This low already counts as the arming low, so a rising edge next
          // cycle is measured.
          armed_d = 1'b1;
        end
      end

      OVERLONG: begin
        if (!s) begin
          state_d = IDLE;
          armed_d = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        armed_d = 1'b0;
      end
    endcase
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      armed_q <= 1'b0;
      ok_q    <= 1'b0;
      short_q <= 1'b0;
      long_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      armed_q <= armed_d;
      ok_q    <= ok_d;
      short_q <= short_d;
      long_q  <= long_d;
    end
  end

  assign ok        = ok_q;
  assign err_short = short_q;
  assign err_long  = long_q;
  assign len       = len_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: doc/pulse_meter.md
PULSE_METER -- requirements
Module: pulse_meter

Interface
REQ-001 Parameter MIN_TICKS, default 3: shortest accepted pulse length, in clk cycles.
REQ-002 Parameter MAX_TICKS, default 8: longest accepted pulse length, in clk cycles.
REQ-003 The block SHALL require 1 <= MIN_TICKS <= MAX_TICKS; other values are unsupported.
REQ-004 clk  in  1  sole clock; all state changes on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 pin  in  1  asynchronous active-high pulse from a remote univib-style monostable.
REQ-007 ok  out  1  one-cycle strobe: pulse ended with length in [MIN_TICKS, MAX_TICKS].
REQ-008 err_short  out  1  one-cycle strobe: pulse ended with length < MIN_TICKS.
REQ-009 err_long  out  1  one-cycle strobe: pulse still high after MAX_TICKS cycles.
REQ-010 len  out  clog2(MAX_TICKS+1)  length of the last completed or aborted pulse; held until the next strobe.
REQ-011 busy  out  1  high while in MEASURE or OVERLONG.

Function
REQ-012 pin SHALL pass a two-flop synchronizer producing s; a third flop s_d SHALL give the edge detect.
REQ-013 FSM states SHALL be IDLE, MEASURE, OVERLONG; an ARMED flag in IDLE is set when s==0.
REQ-014 IDLE: s==1 and s_d==0 and ARMED -> MEASURE, cnt=1; a high s without a seen low SHALL be ignored.
REQ-015 MEASURE, s==1, cnt<MAX_TICKS: cnt increments by 1 per cycle.
REQ-016 MEASURE, s==1, cnt==MAX_TICKS: err_long=1 for one cycle, len=MAX_TICKS, -> OVERLONG.
REQ-017 MEASURE, s==0: len=cnt; ok=1 if cnt>=MIN_TICKS, else err_short=1; -> IDLE; all in the same cycle.
REQ-018 OVERLONG: no strobes; s==0 -> IDLE.
REQ-019 Strobe latency: the strobe SHALL be asserted in the first cycle where s==0 in MEASURE.
REQ-020 Latency from pin: 3 clk cycles after pin falls.
REQ-021 At most one of ok/err_short/err_long SHALL be high in any cycle; each strobe lasts one cycle.
REQ-022 cnt SHALL never exceed MAX_TICKS and never wrap.
REQ-023 Back-to-back pulses: the IDLE cycle entered with s==0 arms the block, so a new rising edge one cycle later SHALL be measured.
REQ-024 busy SHALL equal (state != IDLE), registered with the state.

Reset
REQ-025 reset SHALL force state=IDLE, ARMED=0, cnt=0, len=0, and the sync flops to 0.
REQ-026 reset SHALL force ok=err_short=err_long=busy=0 in the cycle after reset is sampled.
REQ-027 Reset mid-pulse SHALL abort the pulse with no strobe.
REQ-028 After a reset mid-pulse, the block SHALL wait for pin low before accepting a new pulse.

Structure
REQ-029 A shared package SHALL hold the state enumeration (IDLE, MEASURE, OVERLONG).
REQ-030 The length-width function SHALL sit in the shared package so univib and pulse_meter size counters identically.
REQ-031 The synchronizer SHALL be one sub-module, sync2 (two flops, reset to 0), reusable by other bus receivers.
REQ-032 The FSM, counter and strobe logic SHALL live in pulse_meter.

Verification (MIN_TICKS=3, MAX_TICKS=8)
REQ-033 pin high 5 cycles from idle-low -> ok=1 once, len=5, 3 cycles after pin falls; no error strobes.
REQ-034 pin high 1 cycle -> err_short=1 once, len=1; ok never high.
REQ-035 pin high exactly 3 cycles -> ok, len=3; exactly 8 cycles -> ok, len=8; 9 cycles -> err_long, len=8, then no strobe on the fall.
REQ-036 pin high 20 cycles -> err_long asserted once, in the 8th measured cycle; busy high until 3 cycles after the fall; then IDLE.
REQ-037 Reset asserted mid-pulse at cycle 4 -> no strobe; pin still high after reset release -> ignored until pin low; next 4-cycle pulse -> ok, len=4.
REQ-038 Two 4-cycle pulses separated by 1 low cycle -> two ok strobes, each len=4, no missed edge.
